qeciphy_crc_tx_framer: RTL and testbench
========================================

Name: qeciphy_crc_tx_framer

Overview:
- TX-side framer that sits directly upstream of the 64-bit CRC-16/IBM-3740 engine and consumes its result.
- Passes a 64-bit stream frame through unchanged and mirrors every accepted word into the CRC engine.
- After the last word it waits for the engine's two-cycle latency, then appends one trailer word carrying the CRC.
- Clears the engine between frames, because the engine accumulates until its reset is asserted.

Parameters:
- MAX_WORDS, 256: maximum data words per frame; the word that reaches this count is forced as last.
- TRAILER_TAG, 16'hC3C3: tag placed in trailer bits [63:48].

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- s_tdata_i  in  64  upstream data.
- s_tvalid_i  in  1  upstream valid.
- s_tlast_i  in  1  last data word of frame.
- s_tready_o  out  1  upstream ready.
- m_tdata_o  out  64  downstream data.
- m_tvalid_o  out  1  downstream valid.
- m_tlast_o  out  1  high only on the trailer word.
- m_tready_i  in  1  downstream ready.
- crc_tdata_o  out  64  engine data.
- crc_tvalid_o  out  1  engine valid.
- crc_clr_n_o  out  1  engine synchronous clear, active-low.
- crc_i  in  16  engine CRC.
- crc_valid_i  in  1  engine result valid.
- crc_err_o  out  1  sticky: crc_valid_i was low at the sample point.
- len_err_o  out  1  sticky: frame truncated at MAX_WORDS.

Behaviour:
- Reset is asynchronous, active-low. On reset: state CLEAR, word count 0, crc_err_o=0, len_err_o=0, m_tvalid_o=0, s_tready_o=0, crc_tvalid_o=0, crc_clr_n_o=0.
- State machine: CLEAR -> DATA -> WAIT_CRC -> TRAILER -> CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle.
  - crc_clr_n_o=0, s_tready_o=0, m_tvalid_o=0.
  - Clears the word count, then moves to DATA.
  - crc_clr_n_o=1 in every other state.
- DATA (combinational pass-through):
  - m_tdata_o=s_tdata_i, m_tvalid_o=s_tvalid_i, m_tlast_o=0, s_tready_o=m_tready_i.
  - crc_tdata_o=s_tdata_i.
  - crc_tvalid_o=s_tvalid_i & m_tready_i, i.e. the accept handshake, so exactly one engine pulse per accepted word.
  - Each accept increments the 9-bit word count (width $clog2(MAX_WORDS)+1).
  - An accept with s_tlast_i=1 moves to WAIT_CRC.
  - An accept with s_tlast_i=0 while count==MAX_WORDS-1 also moves to WAIT_CRC and sets len_err_o.
  - s_tlast_i is ignored when s_tvalid_i=0.
- WAIT_CRC:
  - Lasts exactly 2 cycles (2-bit down-counter); s_tready_o=0, m_tvalid_o=0.
  - Last word accepted in cycle T; WAIT_CRC occupies T+1 and T+2.
  - At the end of T+2, crc_i is latched into a 16-bit holding register.
  - If crc_valid_i=0 in T+2, crc_err_o is set; the trailer is still sent with the latched value.
- TRAILER:
  - Entered in cycle T+3.
  - m_tdata_o = {TRAILER_TAG, 32'h0, crc_hold}; m_tvalid_o=1, m_tlast_o=1, s_tready_o=0.
  - Held stable until m_tready_i=1, then moves to CLEAR.
- Backpressure:
  - In DATA, m_tready_i=0 stalls upstream, and no CRC pulse is generated for a stalled word.
  - In TRAILER, the output stays stable indefinitely.
- Minimum inter-frame overhead: 4 non-accepting cycles after the last data word with m_tready_i held high (WAIT×2, TRAILER, CLEAR).
- A single-word frame (first word has tlast) is legal.
- Sticky error flags clear only on reset.
- Reset mid-frame:
  - Everything returns to CLEAR immediately; no trailer is emitted.
  - crc_clr_n_o=0 on the first post-reset cycle, so the engine is cleared even if it has a different reset.

Test Plan:
- 3-word frame 64'h1, 64'h2, 64'h3 (tlast on the third), m_tready_i=1, stub crc_i=16'h1234 with crc_valid_i=1 two cycles after each pulse -> output is 3 data words with m_tlast_o=0, then 64'hC3C3_0000_0000_1234 with m_tlast_o=1 exactly 3 cycles after the third accept; crc_tvalid_o pulses 3 times; crc_clr_n_o low for 1 cycle afterwards.
- Same frame with m_tready_i toggled 1,0,1,0 -> no duplicate crc_tvalid_o pulses; trailer held stable during the 0 cycles; output data unchanged.
- With the real CRC engine connected, two back-to-back frames of identical data -> identical trailer CRC values, proving the inter-frame clear; check against a software CRC-16/IBM-3740 model with init 0xFFFF.
- MAX_WORDS=4 with a 6-word frame without tlast -> trailer follows word 4 and len_err_o=1; words 5 and 6 start a new frame; crc_err_o=0.
- Stub holds crc_valid_i=0 -> trailer still sent with the crc_i value and crc_err_o=1 from cycle T+3 onward.
- Assert rst_n_i asynchronously during WAIT_CRC -> outputs take their reset values immediately with no clock edge; no trailer; the next frame's trailer equals that frame's own CRC.

Source files
------------

// File: rtl/qeciphy_crc_tx_framer.sv
// TX framer in front of the 64-bit CRC-16 engine: forwards a frame unchanged,
// mirrors accepted words into the engine, then appends a tagged CRC trailer.
module qeciphy_crc_tx_framer #(
  parameter int          MAX_WORDS   = 256,
  parameter logic [15:0] TRAILER_TAG = 16'hC3C3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] s_tdata_i,
  input  logic        s_tvalid_i,
  input  logic        s_tlast_i,
  output logic        s_tready_o,
  output logic [63:0] m_tdata_o,
  output logic        m_tvalid_o,
  output logic        m_tlast_o,
  input  logic        m_tready_i,
  output logic [63:0] crc_tdata_o,
  output logic        crc_tvalid_o,
  output logic        crc_clr_n_o,
  input  logic [15:0] crc_i,
  input  logic        crc_valid_i,
  output logic        crc_err_o,
  output logic        len_err_o
);

  localparam int            CW       = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  typedef enum logic [1:0] {
    S_CLEAR   = 2'd0,
    S_DATA    = 2'd1,
    S_WAIT    = 2'd2,
    S_TRAILER = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    wait_q, wait_d;
  logic [15:0]   crc_hold_q, crc_hold_d;
  logic          crc_err_q, crc_err_d;
  logic          len_err_q, len_err_d;

  assign crc_err_o = crc_err_q;
  assign len_err_o = len_err_q;

  // State, counters, CRC holding register and sticky error flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_CLEAR;
      cnt_q      <= '0;
      wait_q     <= '0;
      crc_hold_q <= '0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      crc_hold_q <= crc_hold_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
    end
  end

  // Next-state and datapath muxing; all outputs are decoded from the state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wait_d       = wait_q;
    crc_hold_d   = crc_hold_q;
    crc_err_d    = crc_err_q;
    len_err_d    = len_err_q;
    s_tready_o   = 1'b0;
    m_tdata_o    = '0;
    m_tvalid_o   = 1'b0;
    m_tlast_o    = 1'b0;
    crc_tdata_o  = '0;
    crc_tvalid_o = 1'b0;
    crc_clr_n_o  = 1'b1;

    unique case (state_q)
      S_CLEAR: begin
        // One-cycle engine clear so each frame's CRC starts from init
        crc_clr_n_o = 1'b0;
        cnt_d       = '0;
        state_d     = S_DATA;
      end
      S_DATA: begin
        m_tdata_o    = s_tdata_i;
        m_tvalid_o   = s_tvalid_i;
        s_tready_o   = m_tready_i;
        crc_tdata_o  = s_tdata_i;
        // Engine only sees words that actually complete the handshake
        crc_tvalid_o = s_tvalid_i & m_tready_i;
        if (s_tvalid_i && m_tready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (s_tlast_i) begin
            state_d = S_WAIT;
            wait_d  = 2'd1;
          end else if (cnt_q == LAST_IDX) begin
            state_d   = S_WAIT;
            wait_d    = 2'd1;
            len_err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Cover the engine's two-cycle latency, sample its result on the second
        wait_d = wait_q - 2'd1;
        if (wait_q == 2'd0) begin
          crc_hold_d = crc_i;
          if (!crc_valid_i) crc_err_d = 1'b1;
          state_d = S_TRAILER;
        end
      end
      S_TRAILER: begin
        m_tdata_o  = {TRAILER_TAG, 32'h0, crc_hold_q};
        m_tvalid_o = 1'b1;
        m_tlast_o  = 1'b1;
        if (m_tready_i) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_qeciphy_crc_tx_framer.sv
// Scoreboard bench for the CRC TX framer with a behavioural 2-cycle CRC engine.
module tb_qeciphy_crc_tx_framer;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast, m_tready;
  logic        s_tready_o, m_tvalid_o, m_tlast_o;
  logic [63:0] m_tdata_o, crc_tdata_o;
  logic        crc_tvalid_o, crc_clr_n_o, crc_err_o, len_err_o;
  logic [15:0] crc_i;
  logic        crc_valid_i;

  // engine model + stub override
  logic [15:0] acc = 16'hFFFF, eng_crc = 16'h0;
  logic        vld1 = 1'b0, eng_vld = 1'b0;
  logic        stub_en = 1'b0, stub_v0 = 1'b0;
  logic [15:0] stub_val = 16'h0;

  int          n_chk = 0, n_err = 0;
  int          cyc = 0, last_acc = 0, n_pulse = 0, n_clr = 0;
  logic [64:0] sbq[$];
  logic [15:0] fcrc = 16'hFFFF;
  int          fcnt = 0;
  bit          skip_trl = 1'b0, exp_crc_err = 1'b0, tog_en = 1'b0;
  bit          in_trl = 1'b0, hold_prev = 1'b0;
  logic [63:0] hold_data;

  always #5 clk = ~clk;

  qeciphy_crc_tx_framer #(.MAX_WORDS(MAXW), .TRAILER_TAG(16'hC3C3)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready),
    .crc_tdata_o(crc_tdata_o), .crc_tvalid_o(crc_tvalid_o), .crc_clr_n_o(crc_clr_n_o),
    .crc_i(crc_i), .crc_valid_i(crc_valid_i),
    .crc_err_o(crc_err_o), .len_err_o(len_err_o));

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc64(input logic [15:0] c, input logic [63:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = crc_byte(r, d[8*i +: 8]);
    return r;
  endfunction

  // engine: accumulate on pulse, result and valid two cycles after the pulse
  always @(posedge clk) begin
    if (!crc_clr_n_o) acc <= 16'hFFFF;
    else if (crc_tvalid_o) acc <= crc64(acc, crc_tdata_o);
    eng_crc <= acc;
    vld1    <= crc_tvalid_o & crc_clr_n_o;
    eng_vld <= vld1;
  end

  assign crc_i       = stub_en ? stub_val : eng_crc;
  assign crc_valid_i = (stub_en && stub_v0) ? 1'b0 : eng_vld;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, ex, $time);
    end
  endtask

  // monitor: scoreboard pops, trailer latency/stability, pulse and clear counts
  initial begin
    logic [64:0] ex;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_trl = 1'b0; hold_prev = 1'b0;
      end else begin
        if (crc_tvalid_o) n_pulse++;
        if (!crc_clr_n_o) n_clr++;
        if (s_tvalid && s_tready_o) last_acc = cyc;
        if (hold_prev) begin
          chk("hold_data", m_tdata_o, hold_data);
          chk("hold_vld", {63'h0, m_tvalid_o}, 64'h1);
        end
        if (m_tvalid_o && m_tlast_o && !in_trl) begin
          in_trl = 1'b1;
          chk("trl_latency", 64'(cyc - last_acc), 64'd3);
          chk("crc_err_at_trl", {63'h0, crc_err_o}, {63'h0, exp_crc_err});
        end
        if (m_tvalid_o && m_tready) begin
          if (sbq.size() == 0) chk("sb_unexpected", 64'h1, 64'h0);
          else begin
            ex = sbq.pop_front();
            chk("sb_data", m_tdata_o, ex[63:0]);
            chk("sb_last", {63'h0, m_tlast_o}, {63'h0, ex[64]});
          end
          if (m_tlast_o) in_trl = 1'b0;
        end
        hold_prev = m_tvalid_o && !m_tready;
        hold_data = m_tdata_o;
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic l);
    bit ok;
    sbq.push_back({1'b0, d});
    fcrc = crc64(fcrc, d);
    fcnt++;
    if (l || fcnt == MAXW) begin
      if (!skip_trl) sbq.push_back({1'b1, 16'hC3C3, 32'h0, stub_en ? stub_val : fcrc});
      fcrc = 16'hFFFF;
      fcnt = 0;
    end
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_tready_o) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #2;
      if (sbq.size() == 0) begin ok = 1'b1; break; end
    end
    chk("drain", {63'h0, ok}, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0, c0;
    logic [71:0] s;
    logic [15:0] r;

    // model sanity: CRC-16/IBM-3740 check value
    s = "123456789"; r = 16'hFFFF;
    for (int i = 8; i >= 0; i--) r = crc_byte(r, s[8*i +: 8]);
    chk("crc_model_check", {48'h0, r}, 64'h29B1);

    // reset state (upstream valid driven high to expose any pass-through)
    rst_n = 1'b0; s_tdata = 64'hFFFF; s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    #3;
    chk("rst_m_tvalid", {63'h0, m_tvalid_o}, 64'h0);
    chk("rst_s_tready", {63'h0, s_tready_o}, 64'h0);
    chk("rst_crc_tvalid", {63'h0, crc_tvalid_o}, 64'h0);
    chk("rst_crc_clr_n", {63'h0, crc_clr_n_o}, 64'h0);
    chk("rst_errs", {62'h0, crc_err_o, len_err_o}, 64'h0);
    s_tvalid = 1'b0; s_tdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // A: stubbed CRC, 3-word frame, ready held high
    stub_en = 1'b1; stub_val = 16'h1234; stub_v0 = 1'b0;
    p0 = n_pulse;
    send(64'h1, 1'b0); send(64'h2, 1'b0); send(64'h3, 1'b1);
    drain();
    c0 = n_clr;
    repeat (4) @(negedge clk); #1;
    chk("A_pulses", 64'(n_pulse - p0), 64'd3);
    chk("A_clr_cycles", 64'(n_clr - c0), 64'd1);

    // B: same frame with downstream ready toggling 1,0,1,0
    p0 = n_pulse;
    tog_en = 1'b1;
    fork
      while (tog_en) begin @(posedge clk); #1; m_tready = ~m_tready; end
    join_none
    send(64'h1, 1'b0); send(64'h2, 1'b0); send(64'h3, 1'b1);
    drain();
    tog_en = 1'b0;
    @(posedge clk); #3; m_tready = 1'b1;
    chk("B_pulses", 64'(n_pulse - p0), 64'd3);

    // C: real engine, two back-to-back identical frames
    stub_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      send(64'h0123_4567_89AB_CDEF, 1'b0);
      send(64'hFEDC_BA98_7654_3210, 1'b0);
      send(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    end
    drain();
    chk("C_len_err", {63'h0, len_err_o}, 64'h0);

    // D: 6 words with no tlast; truncated after word 4, rest starts a new frame
    for (int w = 1; w <= 6; w++) send(64'h1000 + 64'(w), 1'b0);
    send(64'h1007, 1'b1);
    drain();
    chk("D_len_err", {63'h0, len_err_o}, 64'h1);
    chk("D_crc_err", {63'h0, crc_err_o}, 64'h0);

    // E: single-word frame, engine result never valid
    stub_en = 1'b1; stub_val = 16'hBEEF; stub_v0 = 1'b1; exp_crc_err = 1'b1;
    send(64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    drain();
    chk("E_crc_err_sticky", {63'h0, crc_err_o}, 64'h1);
    stub_en = 1'b0; stub_v0 = 1'b0;

    // F: async reset during WAIT_CRC, then a clean frame
    skip_trl = 1'b1;
    send(64'h11, 1'b0); send(64'h22, 1'b1);
    #3; rst_n = 1'b0; #1;
    chk("F_rst_clr_n", {63'h0, crc_clr_n_o}, 64'h0);
    chk("F_rst_crc_err", {63'h0, crc_err_o}, 64'h0);
    chk("F_rst_len_err", {63'h0, len_err_o}, 64'h0);
    chk("F_rst_m_tvalid", {63'h0, m_tvalid_o}, 64'h0);
    skip_trl = 1'b0; exp_crc_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'h33, 1'b0); send(64'h44, 1'b1);
    drain();
    chk("F_crc_err", {63'h0, crc_err_o}, 64'h0);

    repeat (4) @(posedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
